// File: rtl/mem_access.sv
// mem_access: single-outstanding load/store unit between the execute stage and a req/ack data bus.
// Define MEM_TIMEOUT_EN to abort an access whose dmem_ack has not arrived after TIMEOUT_CYC wait cycles.
module mem_access #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_x_rd_vld,
    input  logic [31:0] EX_x_rd,
    input  logic [4:0]  EX_rd,
    input  logic [31:0] EX_MEMaddr,
    input  logic [3:0]  EX_MEMrden,
    input  logic        EX_MEMrden_SEXT,
    input  logic [3:0]  EX_MEMwren,
    input  logic [31:0] EX_MEMwrdata,
    output logic        dmem_req,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        MEM_x_rd_vld,
    output logic [31:0] MEM_x_rd,
    output logic [4:0]  MEM_rd,
    output logic        MEM_stall,
    output logic        MEM_bus_err
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;
    logic access, tmo, is_load, cap_vld, cap_sext, unused_bits;
    logic [4:0] cap_rd;
    logic [3:0] cap_rden;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    assign access = (EX_MEMrden != 4'b0) || (EX_MEMwren != 4'b0);
    assign is_load = cap_rden != 4'b0;
    assign unused_bits = ^EX_MEMaddr[1:0] ^ (TIMEOUT_CYC != 0);
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1) > 8 ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CW-1:0] wait_cnt;
    // Held at zero while idle so every access starts counting from zero.
    always_ff @(posedge clk)
        if (rst || state == IDLE) wait_cnt <= '0;
        else if (!dmem_ack) wait_cnt <= wait_cnt + 1'b1;
    assign tmo = state == WAIT && !dmem_ack && wait_cnt == CW'(TIMEOUT_CYC - 1);
`else
    assign tmo = 1'b0;
`endif
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    always_comb
        state_nxt = state == IDLE ? (access ? WAIT : IDLE) : (dmem_ack || tmo ? IDLE : WAIT);
    always_comb begin
        MEM_stall = state == WAIT;
        ld_byte = cap_rden[3] ? dmem_rdata[31:24] : cap_rden[2] ? dmem_rdata[23:16] :
                  cap_rden[1] ? dmem_rdata[15:8] : dmem_rdata[7:0];
        ld_half = cap_rden[3] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (cap_rden)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ld_data = {{24{cap_sext & ld_byte[7]}}, ld_byte};
            4'b0011, 4'b1100: ld_data = {{16{cap_sext & ld_half[15]}}, ld_half};
            4'b1111: ld_data = dmem_rdata;
            default: ld_data = 32'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req <= 1'b0;
            dmem_we <= 4'b0;
            dmem_addr <= 32'b0;
            dmem_wdata <= 32'b0;
            MEM_x_rd_vld <= 1'b0;
            MEM_x_rd <= 32'b0;
            MEM_rd <= 5'b0;
            MEM_bus_err <= 1'b0;
            cap_rd <= 5'b0;
            cap_vld <= 1'b0;
            cap_sext <= 1'b0;
            cap_rden <= 4'b0;
        end else begin
            MEM_x_rd_vld <= 1'b0;
            MEM_bus_err <= tmo;
            if (state == IDLE) begin
                if (access) begin
                    dmem_req <= 1'b1;
                    dmem_we <= EX_MEMwren;
                    dmem_addr <= {EX_MEMaddr[31:2], 2'b00};
                    dmem_wdata <= EX_MEMwrdata;
                    cap_rd <= EX_rd;
                    cap_vld <= EX_x_rd_vld;
                    cap_sext <= EX_MEMrden_SEXT;
                    // A store masks out the read lanes so it never produces writeback.
                    cap_rden <= EX_MEMwren != 4'b0 ? 4'b0 : EX_MEMrden;
                end else begin
                    MEM_x_rd_vld <= EX_x_rd_vld;
                    MEM_x_rd <= EX_x_rd;
                    MEM_rd <= EX_rd;
                end
            end else if (dmem_ack) begin
                dmem_req <= 1'b0;
                MEM_rd <= cap_rd;
                MEM_x_rd <= ld_data;
                MEM_x_rd_vld <= cap_vld & is_load;
            end else if (tmo) begin
                dmem_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard-driven bench for mem_access (default build, no timeout).
module tb_mem_access;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        EX_x_rd_vld = 1'b0;
    logic [31:0] EX_x_rd = 32'b0;
    logic [4:0]  EX_rd = 5'b0;
    logic [31:0] EX_MEMaddr = 32'b0;
    logic [3:0]  EX_MEMrden = 4'b0;
    logic        EX_MEMrden_SEXT = 1'b0;
    logic [3:0]  EX_MEMwren = 4'b0;
    logic [31:0] EX_MEMwrdata = 32'b0;
    logic        dmem_req;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'b0;
    logic        dmem_ack = 1'b0;
    logic        MEM_x_rd_vld;
    logic [31:0] MEM_x_rd;
    logic [4:0]  MEM_rd;
    logic        MEM_stall;
    logic        MEM_bus_err;

    typedef struct packed {logic vld; logic [4:0] rd; logic [31:0] data;} res_t;
    res_t sb[$];
    int passed = 0;
    int total = 0;

    mem_access dut (
        .clk(clk), .rst(rst),
        .EX_x_rd_vld(EX_x_rd_vld), .EX_x_rd(EX_x_rd), .EX_rd(EX_rd),
        .EX_MEMaddr(EX_MEMaddr), .EX_MEMrden(EX_MEMrden), .EX_MEMrden_SEXT(EX_MEMrden_SEXT),
        .EX_MEMwren(EX_MEMwren), .EX_MEMwrdata(EX_MEMwrdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .MEM_x_rd_vld(MEM_x_rd_vld), .MEM_x_rd(MEM_x_rd), .MEM_rd(MEM_rd),
        .MEM_stall(MEM_stall), .MEM_bus_err(MEM_bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        EX_x_rd_vld = 1'b0;
        EX_x_rd = 32'b0;
        EX_rd = 5'b0;
        EX_MEMaddr = 32'b0;
        EX_MEMrden = 4'b0;
        EX_MEMrden_SEXT = 1'b0;
        EX_MEMwren = 4'b0;
        EX_MEMwrdata = 32'b0;
    endtask

    // Inputs that would start a store if they were not ignored during WAIT.
    task automatic garbage_inputs;
        EX_x_rd_vld = 1'b1;
        EX_x_rd = 32'hA5A5_A5A5;
        EX_rd = 5'd31;
        EX_MEMaddr = 32'hFFFF_FFF0;
        EX_MEMrden = 4'hF;
        EX_MEMwren = 4'hF;
        EX_MEMwrdata = 32'h1357_9BDF;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, MEM_x_rd_vld, MEM_x_rd, MEM_rd, MEM_stall, MEM_bus_err} !== '0)
            $display("FAIL reset: req=%b we=%h addr=%h wdata=%h vld=%b x_rd=%h rd=%0d stall=%b err=%b, all required 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, MEM_x_rd_vld, MEM_x_rd, MEM_rd, MEM_stall, MEM_bus_err);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic alu(input logic [31:0] d, input logic [4:0] rd);
        res_t e;
        EX_x_rd_vld = 1'b1;
        EX_x_rd = d;
        EX_rd = rd;
        sb.push_back({1'b1, rd, d});
        tick();
        e = sb.pop_front();
        total++;
        if ({MEM_x_rd_vld, MEM_rd, MEM_x_rd} !== e || MEM_stall !== 1'b0)
            $display("FAIL alu: vld=%b rd=%0d x_rd=%h stall=%b, required vld=%b rd=%0d x_rd=%h stall=0",
                     MEM_x_rd_vld, MEM_rd, MEM_x_rd, MEM_stall, e.vld, e.rd, e.data);
        else passed++;
        idle_inputs();
        tick();
        total++;
        if (MEM_x_rd_vld !== 1'b0) $display("FAIL alu_pulse: vld=%b, required 0", MEM_x_rd_vld);
        else passed++;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [3:0] rden, input logic sext,
                           input logic vld, input logic [4:0] rd, input logic [31:0] rdata,
                           input int waitc, input logic [31:0] exp_d, input string name);
        res_t e;
        int stalls = 0;
        EX_x_rd_vld = vld;
        EX_x_rd = 32'h5555_5555;
        EX_rd = rd;
        EX_MEMaddr = addr;
        EX_MEMrden = rden;
        EX_MEMrden_SEXT = sext;
        EX_MEMwren = 4'b0;
        sb.push_back({vld, rd, exp_d});
        tick();
        total++;
        if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 4'b0, addr[31:2], 2'b00})
            $display("FAIL %s_issue: req=%b we=%h addr=%h, required req=1 we=0 addr=%h",
                     name, dmem_req, dmem_we, dmem_addr, {addr[31:2], 2'b00});
        else passed++;
        garbage_inputs();
        for (int i = 0; i < waitc; i++) begin
            if (MEM_stall && !MEM_x_rd_vld && dmem_req && dmem_we == 4'b0 && dmem_addr == {addr[31:2], 2'b00})
                stalls++;
            if (i == waitc - 1) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
                idle_inputs();
            end
            tick();
        end
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0BAD_0BAD;
        e = sb.pop_front();
        total++;
        if ({MEM_x_rd_vld, MEM_rd, MEM_x_rd} !== e)
            $display("FAIL %s_result: vld=%b rd=%0d x_rd=%h, required vld=%b rd=%0d x_rd=%h",
                     name, MEM_x_rd_vld, MEM_rd, MEM_x_rd, e.vld, e.rd, e.data);
        else passed++;
        total++;
        if (stalls != waitc || MEM_stall !== 1'b0 || dmem_req !== 1'b0)
            $display("FAIL %s_wait: held-stall cycles=%0d stall=%b req=%b, required %0d cycles stall=0 req=0",
                     name, stalls, MEM_stall, dmem_req, waitc);
        else passed++;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [3:0] wren, input logic [31:0] wdata,
                            input logic [4:0] rd, input int waitc, input string name);
        res_t e;
        int held = 0;
        EX_x_rd_vld = 1'b1;
        EX_rd = rd;
        EX_MEMaddr = addr;
        EX_MEMrden = 4'hF;
        EX_MEMrden_SEXT = 1'b1;
        EX_MEMwren = wren;
        EX_MEMwrdata = wdata;
        sb.push_back({1'b0, rd, 32'b0});
        tick();
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, wren, addr[31:2], 2'b00, wdata})
            $display("FAIL %s_issue: req=%b we=%h addr=%h wdata=%h, required req=1 we=%h addr=%h wdata=%h",
                     name, dmem_req, dmem_we, dmem_addr, dmem_wdata, wren, {addr[31:2], 2'b00}, wdata);
        else passed++;
        garbage_inputs();
        for (int i = 0; i < waitc; i++) begin
            if (MEM_stall && !MEM_x_rd_vld && dmem_req && dmem_we == wren &&
                dmem_addr == {addr[31:2], 2'b00} && dmem_wdata == wdata)
                held++;
            if (i == waitc - 1) begin
                dmem_ack = 1'b1;
                dmem_rdata = 32'hFFFF_FFFF;
                idle_inputs();
            end
            tick();
        end
        dmem_ack = 1'b0;
        e = sb.pop_front();
        total++;
        if ({MEM_x_rd_vld, MEM_rd} !== {e.vld, e.rd} || held != waitc || dmem_req !== 1'b0)
            $display("FAIL %s_done: vld=%b rd=%0d held=%0d req=%b, required vld=0 rd=%0d held=%0d req=0",
                     name, MEM_x_rd_vld, MEM_rd, held, dmem_req, e.rd, waitc);
        else passed++;
    endtask

    task automatic test_alu;
        alu(32'h0000_1234, 5'd5);
        alu(32'hFFFF_0001, 5'd31);
    endtask

    task automatic test_loads;
        do_load(32'h0000_0103, 4'b1000, 1'b1, 1'b1, 5'd7, 32'h80FF_FFFF, 3, 32'hFFFF_FF80, "lb_sext");
        do_load(32'h0000_0102, 4'b1100, 1'b0, 1'b1, 5'd8, 32'h8001_0000, 1, 32'h0000_8001, "lhu");
        do_load(32'h0000_0104, 4'b1111, 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, "lw");
        do_load(32'h0000_0100, 4'b0001, 1'b0, 1'b1, 5'd10, 32'h1234_56F0, 1, 32'h0000_00F0, "lbu0");
        do_load(32'h0000_0100, 4'b0011, 1'b1, 1'b1, 5'd11, 32'h0000_8765, 2, 32'hFFFF_8765, "lh_low");
        do_load(32'h0000_0101, 4'b0010, 1'b1, 1'b1, 5'd12, 32'h00AA_7F00, 1, 32'h0000_007F, "lb1_pos");
        do_load(32'h0000_0102, 4'b0100, 1'b0, 1'b1, 5'd13, 32'h00AA_7F00, 1, 32'h0000_00AA, "lbu2");
        do_load(32'h0000_0100, 4'b0101, 1'b1, 1'b1, 5'd14, 32'hFFFF_FFFF, 1, 32'h0000_0000, "bad_mask");
        do_load(32'h0000_0108, 4'b1111, 1'b0, 1'b0, 5'd15, 32'h1111_2222, 2, 32'h1111_2222, "lw_novld");
    endtask

    task automatic test_store;
        do_store(32'h0000_0201, 4'b0010, 32'hABAB_ABAB, 5'd3, 4, "sb");
        do_store(32'h0000_0302, 4'b1100, 32'h5A5A_5A5A, 5'd4, 1, "sh");
    endtask

    task automatic test_back_to_back;
        do_load(32'h0000_0400, 4'b1111, 1'b0, 1'b1, 5'd1, 32'h0102_0304, 1, 32'h0102_0304, "b2b_a");
        do_load(32'h0000_0404, 4'b1000, 1'b1, 1'b1, 5'd2, 32'hFE00_0000, 1, 32'hFFFF_FFFE, "b2b_b");
        alu(32'hCAFE_F00D, 5'd6);
    endtask

    task automatic test_rst_in_wait;
        EX_x_rd_vld = 1'b1;
        EX_rd = 5'd20;
        EX_MEMaddr = 32'h0000_0500;
        EX_MEMrden = 4'b1111;
        tick();
        total++;
        if (dmem_req !== 1'b1 || MEM_stall !== 1'b1)
            $display("FAIL rst_wait_issue: req=%b stall=%b, required 1 1", dmem_req, MEM_stall);
        else passed++;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h7777_7777;
        tick();
        dmem_ack = 1'b0;
        total++;
        if ({dmem_req, MEM_x_rd_vld, MEM_stall} !== 3'b000)
            $display("FAIL rst_wait_abort: req=%b vld=%b stall=%b, required 0 0 0", dmem_req, MEM_x_rd_vld, MEM_stall);
        else passed++;
        tick();
        total++;
        if (MEM_x_rd_vld !== 1'b0) $display("FAIL rst_wait_late: vld=%b, required 0", MEM_x_rd_vld);
        else passed++;
        alu(32'h0000_00AB, 5'd21);
    endtask

    task automatic test_ack_idle;
        idle_inputs();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_ack = 1'b0;
        total++;
        if ({dmem_req, MEM_x_rd_vld, MEM_stall, MEM_bus_err} !== 4'b0000)
            $display("FAIL ack_idle: req=%b vld=%b stall=%b err=%b, required all 0",
                     dmem_req, MEM_x_rd_vld, MEM_stall, MEM_bus_err);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_store();
        test_back_to_back();
        test_rst_in_wait();
        test_ack_idle();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL declare parameter TIMEOUT_CYC, default 255, max wait cycles for dmem_ack before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  reset.
REQ-005 EX_x_rd_vld  in  1  writeback request from execute stage.
REQ-006 EX_x_rd  in  32  ALU result.
REQ-007 EX_rd  in  5  destination register index.
REQ-008 EX_MEMaddr  in  32  byte address.
REQ-009 EX_MEMrden  in  4  read byte-lane mask.
REQ-010 EX_MEMrden_SEXT  in  1  sign-extend load result.
REQ-011 EX_MEMwren  in  4  write byte-lane mask.
REQ-012 EX_MEMwrdata  in  32  lane-replicated store data.
REQ-013 dmem_req  out  1  bus request, held until ack.
REQ-014 dmem_we  out  4  byte write strobes; 0 means read.
REQ-015 dmem_addr  out  32  word address, {EX_MEMaddr[31:2],2'b00}.
REQ-016 dmem_wdata  out  32  store data.
REQ-017 dmem_rdata  in  32  read data, valid with dmem_ack.
REQ-018 dmem_ack  in  1  one-cycle completion pulse.
REQ-019 MEM_x_rd_vld  out  1  writeback valid, one-cycle pulse.
REQ-020 MEM_x_rd  out  32  writeback data.
REQ-021 MEM_rd  out  5  writeback register index.
REQ-022 MEM_stall  out  1  pipeline hold request.
REQ-023 MEM_bus_err  out  1  timeout pulse (tied 0 without MEM_TIMEOUT_EN).

Function
REQ-024 SHALL implement states IDLE and WAIT; MEM_stall = (state==WAIT).
REQ-025 In IDLE, access = (EX_MEMrden!=0)|(EX_MEMwren!=0); if EX_MEMwren!=0, EX_MEMrden SHALL be ignored (store).
REQ-026 In IDLE with access, SHALL capture all EX_* inputs, drive dmem_req=1, dmem_we=EX_MEMwren, dmem_addr, dmem_wdata from next edge, and enter WAIT.
REQ-027 In IDLE without access, SHALL register MEM_x_rd_vld=EX_x_rd_vld, MEM_x_rd=EX_x_rd, MEM_rd=EX_rd (1-cycle latency).
REQ-028 In WAIT, EX_* inputs SHALL be ignored; dmem_req and bus outputs SHALL stay constant until dmem_ack.
REQ-029 On dmem_ack in WAIT: next edge dmem_req=0, state IDLE, MEM_rd=captured rd, MEM_x_rd_vld=captured x_rd_vld AND load (0 for store).
REQ-030 Load data: lane mask 0001/0010/0100/1000 selects byte 0/1/2/3; 0011/1100 selects halfword low/high; 1111 full word; result zero- or sign-extended per captured SEXT.
REQ-031 Any other nonzero read mask SHALL yield MEM_x_rd=0 with MEM_x_rd_vld per REQ-029.
REQ-032 MEM_x_rd_vld SHALL be 0 every cycle not covered by REQ-027/REQ-029.
REQ-033 dmem_ack in IDLE SHALL be ignored.
REQ-034 Request at cycle N, ack at cycle M: MEM_stall high N+1..M, result visible at M+1; IDLE at M+1 SHALL accept a new access in the same cycle.

Reset
REQ-035 On rst: state IDLE; dmem_req, dmem_we, MEM_x_rd_vld, MEM_stall, MEM_bus_err = 0; dmem_addr, dmem_wdata, MEM_x_rd, MEM_rd = 0.
REQ-036 rst in WAIT SHALL abort the access (dmem_req 0 next edge); a later ack SHALL be ignored.

Configuration
REQ-037 With MEM_TIMEOUT_EN defined: 8+-bit counter clears on entering WAIT, increments each WAIT cycle without ack; on reaching TIMEOUT_CYC, next edge dmem_req=0, IDLE, MEM_bus_err=1 for one cycle, MEM_x_rd_vld=0.
REQ-038 Without MEM_TIMEOUT_EN: no counter; WAIT held indefinitely; MEM_bus_err constant 0.

Verification
REQ-039 ALU pass-through: EX_x_rd_vld=1, EX_x_rd=0x1234, EX_rd=5, masks 0 -> next cycle MEM_x_rd_vld=1, MEM_x_rd=0x1234, MEM_rd=5, MEM_stall=0.
REQ-040 LB sign: addr 0x103, rden=1000, SEXT=1, rdata=0x80FFFFFF, ack after 3 cycles -> MEM_x_rd=0xFFFFFF80, MEM_stall high exactly 3 cycles.
REQ-041 LHU: addr 0x102, rden=1100, SEXT=0, rdata=0x8001_0000 -> MEM_x_rd=0x00008001.
REQ-042 SB: addr 0x201, wren=0010, wrdata=0xABABABAB -> dmem_addr=0x200, dmem_we=0010, held until ack; MEM_x_rd_vld stays 0.
REQ-043 rst asserted during WAIT, ack arrives next cycle -> dmem_req 0, no MEM_x_rd_vld pulse.
REQ-044 MEM_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> after 4 WAIT cycles MEM_bus_err single pulse, dmem_req drops, IDLE.
